// File: rtl/md5_pkg.sv
// Shared MD5 constants and types for the brute-force match stage.
package md5_pkg;

  localparam int unsigned DIGEST_W = 32;

  localparam logic [DIGEST_W-1:0] MD5_IV_A = 32'h67452301;
  localparam logic [DIGEST_W-1:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [DIGEST_W-1:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [DIGEST_W-1:0] MD5_IV_D = 32'h10325476;

  localparam logic [DIGEST_W-1:0] EXP_DEFAULT_A = 32'h2971bc83;
  localparam logic [DIGEST_W-1:0] EXP_DEFAULT_B = 32'h9b41f6a4;
  localparam logic [DIGEST_W-1:0] EXP_DEFAULT_C = 32'h955620c0;
  localparam logic [DIGEST_W-1:0] EXP_DEFAULT_D = 32'h9067fbfd;

  localparam int unsigned DEF_CNT_W  = 64;
  localparam int unsigned DEF_TEXT_W = 128;

  typedef struct packed {
    logic [DEF_CNT_W-1:0]  index;
    logic [DEF_TEXT_W-1:0] text;
  } match_entry_t;

  function automatic logic digest_eq(
    input logic [DIGEST_W-1:0] a, b, c, d,
    input logic [DIGEST_W-1:0] ea, eb, ec, ed
  );
    return (a == ea) && (b == eb) && (c == ec) && (d == ed);
  endfunction

endpackage

// File: rtl/md5_match_capture_if.sv
// Candidate/digest inputs and host readout bus of the match capture stage.
interface md5_match_capture_if #(
  parameter int unsigned TEXT_W = 128,
  parameter int unsigned CNT_W  = 64
);
  logic              cand_valid;
  logic [TEXT_W-1:0] cand_text;
  logic [31:0]       dig_a, dig_b, dig_c, dig_d;
  logic [31:0]       exp_a, exp_b, exp_c, exp_d;
  logic              rd_pop;
  logic [TEXT_W-1:0] rd_text;
  logic [CNT_W-1:0]  rd_index;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;
  logic              match_pulse;
  logic [7:0]        match_count;
  logic [CNT_W-1:0]  tested_count;

  modport slave (
    input  cand_valid, cand_text, dig_a, dig_b, dig_c, dig_d,
           exp_a, exp_b, exp_c, exp_d, rd_pop,
    output rd_text, rd_index, fifo_empty, fifo_full, overflow,
           match_pulse, match_count, tested_count
  );

  modport master (
    output cand_valid, cand_text, dig_a, dig_b, dig_c, dig_d,
           exp_a, exp_b, exp_c, exp_d, rd_pop,
    input  rd_text, rd_index, fifo_empty, fifo_full, overflow,
           match_pulse, match_count, tested_count
  );
endinterface

// File: rtl/md5_match_fifo.sv
// First-word-fall-through match queue with sticky overflow on dropped pushes.
module md5_match_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 192
) (
  input  logic         clk,
  input  logic         reset2,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         overflow_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q;
  logic          do_push, do_pop, drop;

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == (AW+1)'(DEPTH));
    do_pop  = pop_i && !empty_o;
    // a pop frees the head slot in the same edge, so push-at-full still lands
    do_push = push_i && (!full_o || do_pop);
    drop    = push_i && full_o && !do_pop;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    overflow_o = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (drop) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/md5_match_capture.sv
// Aligns candidates with their MD5 digests via a circular delay RAM and queues hits.
module md5_match_capture
  import md5_pkg::*;
#(
  parameter int unsigned LATENCY = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TEXT_W  = 128,
  parameter int unsigned CNT_W   = 64
) (
  input  logic          clk,
  input  logic          reset2,
  md5_match_capture_if.slave bus
);
  localparam int unsigned PW = $clog2(LATENCY);

  typedef struct packed {
    logic [CNT_W-1:0]  index;
    logic [TEXT_W-1:0] text;
  } entry_t;

  logic [TEXT_W-1:0]  text_ram_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]   tested_q, tested_d;
  logic [7:0]         mcnt_q, mcnt_d;
  logic               pulse_q;
  logic               dly_valid, hit;
  logic [TEXT_W-1:0]  dly_text;
  entry_t             push_e, head_e;
  logic               f_empty, f_full, f_ovf;

  // Slot at ptr holds the candidate written LATENCY cycles ago; read before overwrite.
  always_comb begin
    dly_valid = vld_q[ptr_q];
    dly_text  = text_ram_q[ptr_q];
    hit       = dly_valid && digest_eq(bus.dig_a, bus.dig_b, bus.dig_c, bus.dig_d,
                                       bus.exp_a, bus.exp_b, bus.exp_c, bus.exp_d);
    ptr_d     = (ptr_q == PW'(LATENCY - 1)) ? '0 : ptr_q + PW'(1);
    tested_d  = dly_valid ? tested_q + CNT_W'(1) : tested_q;
    mcnt_d    = (hit && mcnt_q != 8'hFF) ? mcnt_q + 8'd1 : mcnt_q;
    push_e.index = tested_q;
    push_e.text  = dly_text;
  end

  always_ff @(posedge clk) begin
    text_ram_q[ptr_q] <= bus.cand_text;
  end

  always_ff @(posedge clk or posedge reset2) begin
    if (reset2) begin
      vld_q    <= '0;
      ptr_q    <= '0;
      tested_q <= '0;
      mcnt_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      vld_q[ptr_q] <= bus.cand_valid;
      ptr_q        <= ptr_d;
      tested_q     <= tested_d;
      mcnt_q       <= mcnt_d;
      pulse_q      <= hit;
    end
  end

  md5_match_fifo #(
    .DEPTH (DEPTH),
    .W     (CNT_W + TEXT_W)
  ) u_fifo (
    .clk        (clk),
    .reset2     (reset2),
    .push_i     (hit),
    .data_i     (push_e),
    .pop_i      (bus.rd_pop),
    .data_o     (head_e),
    .empty_o    (f_empty),
    .full_o     (f_full),
    .overflow_o (f_ovf)
  );

  assign bus.rd_text      = head_e.text;
  assign bus.rd_index     = head_e.index;
  assign bus.fifo_empty   = f_empty;
  assign bus.fifo_full    = f_full;
  assign bus.overflow     = f_ovf;
  assign bus.match_pulse  = pulse_q;
  assign bus.match_count  = mcnt_q;
  assign bus.tested_count = tested_q;
endmodule

// File: tb/tb_md5_match_capture.sv
// Scoreboard bench for md5_match_capture: a reference delay queue predicts hits and FIFO contents.
module tb_md5_match_capture;
  import md5_pkg::*;

  localparam int unsigned LATENCY = 64;
  localparam int unsigned DEPTH   = 4;

  typedef struct {
    bit           v;
    logic [127:0] t;
  } dl_t;

  typedef struct {
    logic [63:0]  index;
    logic [127:0] text;
  } ent_t;

  logic clk;
  logic reset2;
  int   checks;
  int   failures;

  dl_t         dq[$];
  ent_t        sb[$];
  logic [63:0] m_tested;
  int          m_mcount;
  bit          m_ovf;

  md5_match_capture_if #(.TEXT_W(128), .CNT_W(64)) bus ();

  md5_match_capture #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .TEXT_W  (128),
    .CNT_W   (64)
  ) dut (
    .clk    (clk),
    .reset2 (reset2),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    dl_t z;
    z.v = 1'b0;
    z.t = '0;
    dq.delete();
    sb.delete();
    for (int i = 0; i < int'(LATENCY); i++) dq.push_back(z);
    m_tested = '0;
    m_mcount = 0;
    m_ovf    = 1'b0;
  endtask

  // One clock: drive inputs, advance the reference model, compare pulse and any popped head.
  task automatic step(input bit v, input logic [127:0] t, input bit dm, input bit pop);
    dl_t  f, n;
    ent_t e;
    bit   hit;
    bus.cand_valid = v;
    bus.cand_text  = t;
    bus.dig_a      = dm ? EXP_DEFAULT_A : 32'h0;
    bus.dig_b      = dm ? EXP_DEFAULT_B : 32'h0;
    bus.dig_c      = dm ? EXP_DEFAULT_C : 32'h0;
    bus.dig_d      = dm ? EXP_DEFAULT_D : 32'h0;
    bus.rd_pop     = pop;
    f = dq.pop_front();
    n.v = v;
    n.t = t;
    dq.push_back(n);
    hit = f.v && dm;
    if (pop && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_index !== e.index || bus.rd_text !== e.text) begin
        failures++;
        $display("FAIL pop_head: got idx=%0d text=%h expected idx=%0d text=%h",
                 bus.rd_index, bus.rd_text, e.index, e.text);
      end
    end
    if (hit) begin
      e.index = m_tested;
      e.text  = f.t;
      if (sb.size() < int'(DEPTH)) sb.push_back(e);
      else m_ovf = 1'b1;
      if (m_mcount < 255) m_mcount++;
    end
    if (f.v) m_tested++;
    @(posedge clk);
    #1;
    bus.rd_pop = 1'b0;
    checks++;
    if (bus.match_pulse !== hit) begin
      failures++;
      $display("FAIL match_pulse: got %b expected %b at %0t", bus.match_pulse, hit, $time);
    end
  endtask

  task automatic apply_reset();
    bus.cand_valid = 1'b0;
    bus.cand_text  = '0;
    bus.dig_a = '0; bus.dig_b = '0; bus.dig_c = '0; bus.dig_d = '0;
    bus.rd_pop = 1'b0;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    reset2 = 1'b0;
  endtask

  task automatic test_reset();
    reset2 = 1'b1;
    #1;
    checks++;
    if (bus.rd_text !== '0 || bus.rd_index !== '0 || bus.fifo_empty !== 1'b1 ||
        bus.fifo_full !== 1'b0 || bus.overflow !== 1'b0 || bus.match_pulse !== 1'b0 ||
        bus.match_count !== 8'd0 || bus.tested_count !== '0) begin
      failures++;
      $display("FAIL reset_values: got empty=%b full=%b ovf=%b pulse=%b mc=%0d tc=%0d idx=%0d expected empty=1 rest 0",
               bus.fifo_empty, bus.fifo_full, bus.overflow, bus.match_pulse,
               bus.match_count, bus.tested_count, bus.rd_index);
    end
    apply_reset();
  endtask

  task automatic test_alignment();
    apply_reset();
    for (int i = 0; i <= 80; i++) begin
      step(i <= 10, (i == 10) ? 128'h61616161 : 128'(i + 1000), i == 74, 1'b0);
      if (i == 74) begin
        checks++;
        if (bus.match_pulse !== 1'b1 || bus.rd_text !== 128'h61616161 ||
            bus.rd_index !== 64'd10 || bus.fifo_empty !== 1'b0) begin
          failures++;
          $display("FAIL alignment: got pulse=%b text=%h idx=%0d empty=%b expected 1 61616161 10 0",
                   bus.match_pulse, bus.rd_text, bus.rd_index, bus.fifo_empty);
        end
      end
    end
    checks++;
    if (bus.tested_count !== 64'd11 || bus.match_count !== 8'd1) begin
      failures++;
      $display("FAIL align_counts: got tc=%0d mc=%0d expected 11 1", bus.tested_count, bus.match_count);
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_post_reset_ignore();
    apply_reset();
    for (int i = 0; i < 100; i++) step(1'b0, 128'(i), 1'b1, 1'b0);
    checks++;
    if (bus.tested_count !== '0 || bus.match_count !== 8'd0 || bus.fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ignore: got tc=%0d mc=%0d empty=%b expected 0 0 1",
               bus.tested_count, bus.match_count, bus.fifo_empty);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 72; i++)
      step(i < 6, 128'(i + 32'h100), (i >= 64) && (i < 70), 1'b0);
    checks++;
    if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b1 || bus.match_count !== 8'd6 ||
        bus.overflow !== m_ovf || int'(bus.match_count) != m_mcount) begin
      failures++;
      $display("FAIL overflow_state: got full=%b ovf=%b mc=%0d expected 1 1 6",
               bus.fifo_full, bus.overflow, bus.match_count);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.rd_index !== 64'(k)) begin
        failures++;
        $display("FAIL overflow_order: got idx=%0d expected %0d", bus.rd_index, k);
      end
      step(1'b0, '0, 1'b0, 1'b1);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_drain: got empty=%b full=%b ovf=%b expected 1 0 1",
               bus.fifo_empty, bus.fifo_full, bus.overflow);
    end
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    for (int i = 0; i < 72; i++) begin
      if (i == 68) begin
        checks++;
        if (bus.fifo_full !== 1'b1 || bus.rd_index !== 64'd0) begin
          failures++;
          $display("FAIL full_before_pop: got full=%b idx=%0d expected 1 0", bus.fifo_full, bus.rd_index);
        end
      end
      step(i < 5, 128'(i + 32'h200), (i >= 64) && (i < 69), i == 68);
    end
    checks++;
    if (bus.overflow !== 1'b0 || bus.fifo_full !== 1'b1 || bus.rd_index !== 64'd1 ||
        bus.rd_text !== 128'h201) begin
      failures++;
      $display("FAIL push_pop_full: got ovf=%b full=%b idx=%0d text=%h expected 0 1 1 201",
               bus.overflow, bus.fifo_full, bus.rd_index, bus.rd_text);
    end
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL push_pop_drain: got empty=%b expected 1", bus.fifo_empty);
    end
  endtask

  task automatic test_midflight_reset();
    apply_reset();
    for (int i = 0; i < 70; i++) step(i < 30, 128'(i + 32'h300), 1'b0, 1'b0);
    reset2 = 1'b1;
    #1;
    checks++;
    if (bus.tested_count !== '0 || bus.match_count !== 8'd0 || bus.fifo_empty !== 1'b1 ||
        bus.match_pulse !== 1'b0 || bus.overflow !== 1'b0 || bus.fifo_full !== 1'b0) begin
      failures++;
      $display("FAIL midflight_reset_values: got tc=%0d mc=%0d empty=%b pulse=%b expected 0 0 1 0",
               bus.tested_count, bus.match_count, bus.fifo_empty, bus.match_pulse);
    end
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    model_clear();
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.match_count !== 8'd0 || bus.fifo_empty !== 1'b1 || bus.tested_count !== '0) begin
      failures++;
      $display("FAIL midflight_stale: got mc=%0d empty=%b tc=%0d expected 0 1 0",
               bus.match_count, bus.fifo_empty, bus.tested_count);
    end
    for (int i = 0; i <= int'(LATENCY); i++) step(i == 0, 128'hbeef, 1'b1, 1'b0);
    checks++;
    if (bus.match_count !== 8'd1 || bus.rd_text !== 128'hbeef || bus.rd_index !== '0) begin
      failures++;
      $display("FAIL midflight_first_hit: got mc=%0d text=%h idx=%0d expected 1 beef 0",
               bus.match_count, bus.rd_text, bus.rd_index);
    end
  endtask

  task automatic test_counter();
    apply_reset();
    for (int i = 0; i < 1070; i++) step(i < 1000, 128'(i), i == 999 + int'(LATENCY), 1'b0);
    checks++;
    if (bus.tested_count !== 64'd1000 || bus.rd_index !== 64'd999 || bus.match_count !== 8'd1 ||
        bus.tested_count !== m_tested) begin
      failures++;
      $display("FAIL counter: got tc=%0d idx=%0d mc=%0d expected 1000 999 1",
               bus.tested_count, bus.rd_index, bus.match_count);
    end
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.exp_a = EXP_DEFAULT_A;
    bus.exp_b = EXP_DEFAULT_B;
    bus.exp_c = EXP_DEFAULT_C;
    bus.exp_d = EXP_DEFAULT_D;
    bus.cand_valid = 1'b0;
    bus.cand_text  = '0;
    bus.dig_a = '0; bus.dig_b = '0; bus.dig_c = '0; bus.dig_d = '0;
    bus.rd_pop = 1'b0;
    model_clear();
    test_reset();
    test_alignment();
    test_post_reset_ignore();
    test_overflow();
    test_push_pop_full();
    test_midflight_reset();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
